// File: rtl/arinc429_tx_line.sv
// ARINC 429 bipolar RZ transmitter: one 32-bit word per valid/ready handshake,
// LSB (ARINC bit 1) first, followed by a null gap, with optional odd parity in bit 32.
module arinc429_tx_line #(
  parameter int HALF_BIT_CLKS = 2,
  parameter int GAP_BITS      = 4,
  parameter int PAR_EN        = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        line_A,
  output logic        line_B,
  output logic        busy,
  output logic        tx_done
);

  localparam int HW       = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
  localparam int GAP_CLKS = 2 * GAP_BITS * HALF_BIT_CLKS;
  localparam int GW       = $clog2(GAP_CLKS);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CLKS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);

  typedef enum logic [1:0] {IDLE, DATA, GAP} state_t;

  state_t          state, state_d;
  logic [4:0]      bit_cnt, bit_d;
  logic [HW-1:0]   half_cnt, half_d;
  logic [GW-1:0]   gap_cnt, gap_d;
  logic            drv, drv_d;
  logic [31:0]     shreg, shreg_d;
  logic            line_a_d, line_b_d, ready_d, busy_d, done_d;

  function automatic logic odd_par(input logic [30:0] d);
    return ~^d;
  endfunction

  function automatic logic [31:0] frame_word(input logic [31:0] d);
    logic top;
    top = (PAR_EN != 0) ? odd_par(d[30:0]) : d[31];
    return {top, d[30:0]};
  endfunction

  // Next-state and next-output logic; outputs are registered from the next position
  always_comb begin
    state_d = state;
    bit_d   = bit_cnt;
    half_d  = half_cnt;
    gap_d   = gap_cnt;
    drv_d   = drv;
    shreg_d = shreg;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d = DATA;
          bit_d   = '0;
          half_d  = '0;
          drv_d   = 1'b1;
          shreg_d = frame_word(tx_data);
        end
      end
      DATA: begin
        if (half_cnt == HALF_LAST) begin
          half_d = '0;
          if (drv) begin
            drv_d = 1'b0;
          end else if (bit_cnt == 5'd31) begin
            state_d = GAP;
            bit_d   = '0;
            gap_d   = '0;
          end else begin
            bit_d   = bit_cnt + 5'd1;
            drv_d   = 1'b1;
            shreg_d = {1'b0, shreg[31:1]};
          end
        end else begin
          half_d = half_cnt + HW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    line_a_d = (state_d == DATA) && drv_d && shreg_d[0];
    line_b_d = (state_d == DATA) && drv_d && !shreg_d[0];
    ready_d  = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
    done_d   = (state == DATA) && (state_d == GAP);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      half_cnt <= '0;
      gap_cnt  <= '0;
      drv      <= 1'b0;
      line_A   <= 1'b0;
      line_B   <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_d;
      half_cnt <= half_d;
      gap_cnt  <= gap_d;
      drv      <= drv_d;
      line_A   <= line_a_d;
      line_B   <= line_b_d;
      tx_ready <= ready_d;
      busy     <= busy_d;
      tx_done  <= done_d;
    end
  end

  // Shift register is pure data; a reset returns the FSM to IDLE so its contents are don't-care
  always_ff @(posedge clock) begin
    shreg <= shreg_d;
  end

endmodule
